// File: rtl/kds_window_buffer_pkg.sv
// ---------------------------------------------------------------------------
// kds_pkg : shared types, default sizes and one-hot helper for the window buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package kds_pkg;

  localparam int IO_DATA_WIDTH_DEF = 16;
  localparam int KERNEL_SIZE_DEF   = 3;
  localparam int NB_LANES_DEF      = 12;
  localparam int LOG2_OF_DEPTH_DEF = 3;

  typedef logic [IO_DATA_WIDTH_DEF-1:0] word_t;
  typedef word_t [KERNEL_SIZE_DEF-1:0]  entry_t;

  // Vectors narrower than 64 bits are zero-extended by the caller.
  function automatic logic onehot_check(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/kds_window_buffer_lane.sv
// ---------------------------------------------------------------------------
// kds_lane : one circular lane with replace / rotate / pop / push handling
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module kds_lane #(
  parameter int W          = 16,
  parameter int K          = 3,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic                  recirc_en,
  input  logic [K*W-1:0]        in_data,
  output logic [K*W-1:0]        head,
  output logic                  valid,
  output logic [LOG2_DEPTH:0]   count
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   CNT_ONE = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE = LOG2_DEPTH'(1);

  logic [K*W-1:0]        mem [DEPTH];
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH:0]   cnt;
  logic                  pop;
  logic                  wr_en;
  logic [K*W-1:0]        wr_data;

  // A load wins the tail slot over recirculation: that is the sliding-window update.
  always_comb begin
    pop     = shift_en & (cnt != '0);
    wr_en   = load | (pop & recirc_en);
    wr_data = load ? in_data : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst_in || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (load && !pop)       cnt <= cnt + CNT_ONE;
      else if (pop && !wr_en) cnt <= cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in && !flush && wr_en) mem[wr_ptr] <= wr_data;
  end

  assign valid = (cnt != '0);
  assign head  = valid ? mem[rd_ptr] : '0;
  assign count = cnt;

endmodule

`default_nettype wire

// File: rtl/kds_window_buffer.sv
// ---------------------------------------------------------------------------
// kds_window_buffer : NB_LANES circular kernel-column lanes feeding the PE array
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module kds_window_buffer
  import kds_pkg::*;
#(
  parameter int IO_DATA_WIDTH = IO_DATA_WIDTH_DEF,
  parameter int KERNEL_SIZE   = KERNEL_SIZE_DEF,
  parameter int NB_LANES      = NB_LANES_DEF,
  parameter int LOG2_OF_DEPTH = LOG2_OF_DEPTH_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst_in,
  input  logic [KERNEL_SIZE*IO_DATA_WIDTH-1:0]       in_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [NB_LANES-1:0]                        lane_select,
  input  logic                                       shift_en,
  input  logic                                       recirc_en,
  input  logic                                       flush,
  output logic [NB_LANES*KERNEL_SIZE*IO_DATA_WIDTH-1:0] out_data,
  output logic [NB_LANES-1:0]                        out_valid,
  output logic [NB_LANES*(LOG2_OF_DEPTH+1)-1:0]      lane_count
);

  localparam int EW = KERNEL_SIZE * IO_DATA_WIDTH;
  localparam int CW = LOG2_OF_DEPTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(1 << LOG2_OF_DEPTH);

  logic [NB_LANES-1:0] room;
  logic [NB_LANES-1:0] load;
  logic                accept;

  // A full lane only has room if its head leaves this cycle; full implies non-empty.
  always_comb begin
    for (int i = 0; i < NB_LANES; i++) begin
      room[i] = (lane_count[i*CW +: CW] != FULL_CNT) | shift_en;
    end
    in_ready = onehot_check(64'(lane_select)) & (|(lane_select & room));
    accept   = in_valid & in_ready;
    load     = lane_select & {NB_LANES{accept}};
  end

  for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
    kds_lane #(
      .W          (IO_DATA_WIDTH),
      .K          (KERNEL_SIZE),
      .LOG2_DEPTH (LOG2_OF_DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst_in    (rst_in),
      .flush     (flush),
      .load      (load[i]),
      .shift_en  (shift_en),
      .recirc_en (recirc_en),
      .in_data   (in_data),
      .head      (out_data[i*EW +: EW]),
      .valid     (out_valid[i]),
      .count     (lane_count[i*CW +: CW])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_kds_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_kds_window_buffer : directed vector table plus multi-cycle corner sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_kds_window_buffer;
  import kds_pkg::*;

  localparam int NL = 12;
  localparam int EW = 48;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_in;
  entry_t            in_data;
  logic              in_valid;
  logic              in_ready;
  logic [NL-1:0]     lane_select;
  logic              shift_en;
  logic              recirc_en;
  logic              flush;
  logic [NL*EW-1:0]  out_data;
  logic [NL-1:0]     out_valid;
  logic [NL*CW-1:0]  lane_count;

  int checks   = 0;
  int failures = 0;

  kds_window_buffer dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .lane_select (lane_select),
    .shift_en    (shift_en),
    .recirc_en   (recirc_en),
    .flush       (flush),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .lane_count  (lane_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [NL-1:0] sel;
    logic          sh;
    logic          rc;
    entry_t        d;
    logic          exp_rdy;
    int            lane;
    int            exp_cnt;
    entry_t        exp_head;
  } vec_t;

  function automatic entry_t mk(input int a, input int b, input int c);
    entry_t e;
    e[0] = a[15:0];
    e[1] = b[15:0];
    e[2] = c[15:0];
    return e;
  endfunction

  function automatic vec_t mv(input logic v, input logic [NL-1:0] sel, input logic sh,
                              input logic rc, input entry_t d, input logic rdy,
                              input int lane, input int cnt, input entry_t hd);
    vec_t r;
    r.v = v; r.sel = sel; r.sh = sh; r.rc = rc; r.d = d; r.exp_rdy = rdy;
    r.lane = lane; r.exp_cnt = cnt; r.exp_head = hd;
    return r;
  endfunction

  function automatic logic [NL-1:0] sel_of(input int lane);
    logic [NL-1:0] s;
    s = '0;
    s[lane] = 1'b1;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_lane(input string tag, input int lane, input int cnt, input entry_t hd);
    chk({tag, ".count"}, 64'(lane_count[lane*CW +: CW]), 64'(cnt));
    chk({tag, ".valid"}, 64'(out_valid[lane]), 64'(cnt > 0));
    chk({tag, ".head"}, 64'(out_data[lane*EW +: EW]), 64'(hd));
  endtask

  task automatic check_all_empty(input string tag);
    for (int l = 0; l < NL; l++) begin
      check_lane($sformatf("%s.l%0d", tag, l), l, 0, '0);
    end
  endtask

  // Drive on the falling edge, sample in_ready before the rising edge, then idle controls.
  task automatic cycle(input logic v, input logic [NL-1:0] sel, input logic sh, input logic rc,
                       input logic fl, input logic rs, input entry_t d,
                       input logic exp_rdy, input string tag);
    @(negedge clk);
    in_valid = v; lane_select = sel; shift_en = sh; recirc_en = rc;
    flush = fl; rst_in = rs; in_data = d;
    #1;
    chk({tag, ".ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    in_valid = 1'b0; shift_en = 1'b0; recirc_en = 1'b0; flush = 1'b0; rst_in = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    rst_in = 1'b1; in_valid = 1'b0; lane_select = sel_of(0); shift_en = 1'b0;
    recirc_en = 1'b0; flush = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    @(negedge clk);

    // Reset then idle
    check_all_empty("reset");
    chk("reset.ready", 64'(in_ready), 64'd1);

    // Lane 0 load / shift, non-one-hot selects
    vecs[0] = mv(1, 12'h001, 0, 0, mk(1,2,3), 1, 0, 1, mk(1,2,3));
    vecs[1] = mv(1, 12'h001, 0, 0, mk(4,5,6), 1, 0, 2, mk(1,2,3));
    vecs[2] = mv(1, 12'h001, 0, 0, mk(7,8,9), 1, 0, 3, mk(1,2,3));
    vecs[3] = mv(0, 12'h001, 1, 0, mk(0,0,0), 1, 0, 2, mk(4,5,6));
    vecs[4] = mv(1, 12'h003, 0, 0, mk(9,9,9), 0, 0, 2, mk(4,5,6));
    vecs[5] = mv(0, 12'h002, 0, 0, mk(0,0,0), 1, 1, 0, mk(0,0,0));
    vecs[6] = mv(1, 12'h000, 0, 0, mk(8,8,8), 0, 0, 2, mk(4,5,6));
    vecs[7] = mv(0, 12'h001, 1, 0, mk(0,0,0), 1, 0, 1, mk(7,8,9));
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].v, vecs[i].sel, vecs[i].sh, vecs[i].rc, 1'b0, 1'b0, vecs[i].d,
            vecs[i].exp_rdy, $sformatf("vec%0d", i));
      check_lane($sformatf("vec%0d", i), vecs[i].lane, vecs[i].exp_cnt, vecs[i].exp_head);
    end
    check_lane("vec.l1_untouched", 1, 0, '0);

    // Fill lane 5, then replace-load into the full lane while shifting
    for (int i = 0; i < 8; i++) begin
      cycle(1, sel_of(5), 0, 0, 0, 0, mk(16'h50+i, 16'h60+i, 16'h70+i), 1, $sformatf("fill%0d", i));
    end
    check_lane("full", 5, 8, mk(16'h50, 16'h60, 16'h70));
    cycle(0, sel_of(5), 0, 0, 0, 0, '0, 0, "full_noshift");
    cycle(1, sel_of(5), 1, 0, 0, 0, mk(16'hA, 16'hB, 16'hC), 1, "full_replace");
    check_lane("full_replace", 5, 8, mk(16'h51, 16'h61, 16'h71));
    check_lane("lane0_popped", 0, 0, '0);
    for (int k = 1; k <= 7; k++) begin
      cycle(0, sel_of(5), 1, 0, 0, 0, '0, 1, $sformatf("drain%0d", k));
      if (k < 7) check_lane($sformatf("drain%0d", k), 5, 8 - k, mk(16'h51+k, 16'h61+k, 16'h71+k));
      else       check_lane("drain7", 5, 1, mk(16'hA, 16'hB, 16'hC));
    end

    // Lane 2 recirculation
    for (int i = 0; i < 4; i++) begin
      cycle(1, sel_of(2), 0, 0, 0, 0, mk(16'h20+i, 16'h30+i, 16'h40+i), 1, $sformatf("l2load%0d", i));
    end
    for (int k = 1; k <= 4; k++) begin
      cycle(0, sel_of(2), 1, 1, 0, 0, '0, 1, $sformatf("rot%0d", k));
      check_lane($sformatf("rot%0d", k), 2, 4, mk(16'h20+(k%4), 16'h30+(k%4), 16'h40+(k%4)));
    end
    check_lane("rot_l5_self", 5, 1, mk(16'hA, 16'hB, 16'hC));
    // Load and recirculate together: load takes the tail, popped head is dropped
    cycle(1, sel_of(2), 1, 1, 0, 0, mk(16'h24, 16'h34, 16'h44), 1, "rot_replace");
    check_lane("rot_replace", 2, 4, mk(16'h21, 16'h31, 16'h41));
    for (int k = 2; k <= 4; k++) begin
      cycle(0, sel_of(2), 1, 1, 0, 0, '0, 1, $sformatf("rot_after%0d", k));
      check_lane($sformatf("rot_after%0d", k), 2, 4, mk(16'h20+k, 16'h30+k, 16'h40+k));
    end

    // Non-one-hot select leaves lanes alone, then flush discards a concurrent load
    cycle(1, 12'h003, 0, 0, 0, 0, mk(1,1,1), 0, "twohot");
    check_lane("twohot.l0", 0, 0, '0);
    check_lane("twohot.l2", 2, 4, mk(16'h24, 16'h34, 16'h44));
    cycle(1, sel_of(0), 0, 0, 1, 0, mk(5,5,5), 1, "flush");
    check_all_empty("flush");

    // Reset while loading and shifting
    cycle(1, sel_of(1), 0, 0, 0, 0, mk(3,3,3), 1, "preset0");
    cycle(1, sel_of(1), 0, 0, 0, 0, mk(4,4,4), 1, "preset1");
    check_lane("preset", 1, 2, mk(3,3,3));
    cycle(1, sel_of(1), 1, 1, 0, 1, mk(6,6,6), 1, "midreset");
    check_all_empty("midreset");
    lane_select = sel_of(0);
    #1;
    chk("midreset.ready", 64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
